// File: rtl/ariane_pkg.sv
// Fetch entry format handed from the frontend to decode, and the fetch queue state type.
package ariane_pkg;

    typedef struct packed {
        logic [2:0]  cf;
        logic [31:0] predict_address;
    } branchpredict_sbe_t;

    typedef struct packed {
        logic [31:0] cause;
        logic [31:0] tval;
        logic        valid;
    } exception_t;

    typedef struct packed {
        logic [31:0]        address;
        logic [31:0]        instruction;
        branchpredict_sbe_t branch_predict;
        exception_t         ex;
    } fetch_entry_t;

    typedef enum logic {
        ACCEPT  = 1'b0,
        EX_HOLD = 1'b1
    } fq_state_e;

endpackage

// File: rtl/config_pkg.sv
// Core configuration type shared across the frontend; passed through as a parameter so
// block instances stay type-consistent with the rest of the core.
package config_pkg;

    typedef struct packed {
        int unsigned nr_commit_ports;
        int unsigned xlen;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '0;

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Read/write pointers and occupancy for a DEPTH-entry circular buffer; updates one cycle
// after push/pop, clr wins over both. Caller must not push when full or pop when empty.
module fifo_ptr_ctrl #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       clr_i,
    output logic [$clog2(DEPTH)-1:0]   wr_ptr_o,
    output logic [$clog2(DEPTH)-1:0]   rd_ptr_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] CountFull = CW'(DEPTH);

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clr_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push_i) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (pop_i) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (push_i && !pop_i) begin
                r_count <= r_count + CW'(1);
            end else if (!push_i && pop_i) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    assign wr_ptr_o = r_wr_ptr;
    assign rd_ptr_o = r_rd_ptr;
    assign count_o  = r_count;
    assign full_o   = (r_count == CountFull);
    assign empty_o  = (r_count == '0);

endmodule

// File: rtl/fetch_entry_queue.sv
// Fetch-to-decode decoupling queue: push visible at the head one cycle later, no bypass.
// Ready is purely registered; it drops when full or while an exception entry is queued.
module fetch_entry_queue
    import ariane_pkg::*;
#(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
    parameter int unsigned           DEPTH   = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  fetch_entry_t             fetch_entry_i,
    input  logic                     fetch_entry_valid_i,
    output logic                     fetch_entry_ready_o,
    output fetch_entry_t             fetch_entry_o,
    output logic                     fetch_entry_valid_o,
    input  logic                     fetch_entry_ready_i,
    output logic [$clog2(DEPTH):0]   usage_o,
    output logic                     ex_block_o
);

    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned CfgW = $bits(CVA6Cfg);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CfgW == 0) begin : g_bad_param
        $error("fetch_entry_queue: DEPTH must be a power of two >= 2");
    end

    fetch_entry_t  r_mem [DEPTH];
    fq_state_e     r_state;

    logic [PW-1:0] w_wr_ptr;
    logic [PW-1:0] w_rd_ptr;
    logic [PW:0]   w_count;
    logic          w_full;
    logic          w_empty;
    logic          w_ready;
    logic          w_valid;
    logic          w_push;
    logic          w_pop;
    fetch_entry_t  w_head;

    assign w_ready = !w_full && (r_state == ACCEPT);
    assign w_valid = !w_empty;
    assign w_push  = fetch_entry_valid_i && w_ready && !flush_i;
    assign w_pop   = w_valid && fetch_entry_ready_i && !flush_i;
    assign w_head  = r_mem[w_rd_ptr];

    fifo_ptr_ctrl #(
        .DEPTH (DEPTH)
    ) u_ptr_ctrl (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push_i   (w_push),
        .pop_i    (w_pop),
        .clr_i    (flush_i),
        .wr_ptr_o (w_wr_ptr),
        .rd_ptr_o (w_rd_ptr),
        .count_o  (w_count),
        .full_o   (w_full),
        .empty_o  (w_empty)
    );

    // Storage is cleared only by reset so the head reads as zero out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[w_wr_ptr] <= fetch_entry_i;
        end
    end

    // Everything fetched behind an exception is wrong-path, so hold until it is consumed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ACCEPT;
        end else begin
            case (r_state)
                ACCEPT: begin
                    if (w_push && fetch_entry_i.ex.valid) begin
                        r_state <= EX_HOLD;
                    end
                end
                EX_HOLD: begin
                    if (flush_i || (w_pop && w_head.ex.valid)) begin
                        r_state <= ACCEPT;
                    end
                end
                default: r_state <= ACCEPT;
            endcase
        end
    end

    assign fetch_entry_ready_o = w_ready;
    assign fetch_entry_o       = w_head;
    assign fetch_entry_valid_o = w_valid;
    assign usage_o             = w_count;
    assign ex_block_o          = (r_state == EX_HOLD);

endmodule

// File: tb/tb_fetch_entry_queue.sv
// Bench for fetch_entry_queue: directed vector table, hand corner sequences, random traffic
// against a queue-based reference model.
module tb_fetch_entry_queue;
    import ariane_pkg::*;

    localparam int DEPTH = 4;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         flush_i;
    fetch_entry_t fetch_entry_i;
    logic         fetch_entry_valid_i;
    logic         fetch_entry_ready_o;
    fetch_entry_t fetch_entry_o;
    logic         fetch_entry_valid_o;
    logic         fetch_entry_ready_i;
    logic [2:0]   usage_o;
    logic         ex_block_o;

    fetch_entry_queue #(
        .CVA6Cfg (config_pkg::cva6_cfg_empty),
        .DEPTH   (DEPTH)
    ) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .flush_i             (flush_i),
        .fetch_entry_i       (fetch_entry_i),
        .fetch_entry_valid_i (fetch_entry_valid_i),
        .fetch_entry_ready_o (fetch_entry_ready_o),
        .fetch_entry_o       (fetch_entry_o),
        .fetch_entry_valid_o (fetch_entry_valid_o),
        .fetch_entry_ready_i (fetch_entry_ready_i),
        .usage_o             (usage_o),
        .ex_block_o          (ex_block_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the queued entries in order, plus "an exception entry is queued".
    fetch_entry_t mq[$];
    bit           mhold;

    typedef struct {
        logic        vin;
        logic        rdy;
        logic        fl;
        logic        exv;
        logic [31:0] addr;
        logic        e_rdy;
        logic        e_vld;
        int          e_use;
        logic        e_blk;
    } vec_t;

    vec_t tbl[$];

    function automatic fetch_entry_t mk(input logic [31:0] addr, input logic exv);
        fetch_entry_t e;
        e.address                        = addr;
        e.instruction                    = addr ^ 32'h1357_9bdf;
        e.branch_predict.cf              = addr[4:2];
        e.branch_predict.predict_address = addr + 32'd4;
        e.ex.cause                       = exv ? 32'd1 : 32'd0;
        e.ex.tval                        = exv ? addr : 32'd0;
        e.ex.valid                       = exv;
        return e;
    endfunction

    function automatic vec_t v(input logic vin, input logic rdy, input logic fl, input logic exv,
                               input logic [31:0] addr, input logic er, input logic ev,
                               input int eu, input logic eb);
        vec_t r;
        r.vin = vin; r.rdy = rdy; r.fl = fl; r.exv = exv; r.addr = addr;
        r.e_rdy = er; r.e_vld = ev; r.e_use = eu; r.e_blk = eb;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_entry(input string name, input fetch_entry_t act, input fetch_entry_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare outputs with the model, apply one clock, advance the model.
    task automatic step(input logic vin, input logic rdy, input logic fl, input fetch_entry_t e);
        bit m_ready, m_valid, m_push, m_pop;
        fetch_entry_t head;
        fetch_entry_valid_i = vin;
        fetch_entry_ready_i = rdy;
        flush_i             = fl;
        fetch_entry_i       = e;
        m_ready = (mq.size() != DEPTH) && !mhold;
        m_valid = (mq.size() != 0);
        chk("model_ready", 64'(fetch_entry_ready_o), 64'(m_ready));
        chk("model_valid", 64'(fetch_entry_valid_o), 64'(m_valid));
        chk("model_usage", 64'(usage_o), 64'(mq.size()));
        chk("model_exblk", 64'(ex_block_o), 64'(mhold));
        if (m_valid) chk_entry("model_head", fetch_entry_o, mq[0]);
        m_push = vin && m_ready && !fl;
        m_pop  = m_valid && rdy && !fl;
        @(posedge clk_i);
        #1;
        if (fl) begin
            mq.delete();
            mhold = 1'b0;
        end else begin
            if (m_pop) begin
                head = mq.pop_front();
                if (head.ex.valid) mhold = 1'b0;
            end
            if (m_push) begin
                mq.push_back(e);
                if (e.ex.valid) mhold = 1'b1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, mk(32'h0, 1'b0));
    endtask

    initial begin
        rst_ni = 1'b0; flush_i = 1'b0; fetch_entry_valid_i = 1'b0; fetch_entry_ready_i = 1'b0;
        fetch_entry_i = '0;
        mhold = 1'b0;

        // Single entry, fill/backpressure with wrap, exception hold.
        tbl.push_back(v(1,0,0,0,32'h8000_0000, 1,0,0,0));
        tbl.push_back(v(0,1,0,0,32'h0,         1,1,1,0));
        tbl.push_back(v(0,0,0,0,32'h0,         1,0,0,0));
        tbl.push_back(v(1,0,0,0,32'h1000_0000, 1,0,0,0));
        tbl.push_back(v(1,0,0,0,32'h1000_0004, 1,1,1,0));
        tbl.push_back(v(1,0,0,0,32'h1000_0008, 1,1,2,0));
        tbl.push_back(v(1,0,0,0,32'h1000_000c, 1,1,3,0));
        tbl.push_back(v(1,0,0,0,32'h1000_0010, 0,1,4,0));
        tbl.push_back(v(1,1,0,0,32'h1000_0010, 0,1,4,0));
        tbl.push_back(v(0,1,0,0,32'h0,         1,1,3,0));
        tbl.push_back(v(0,1,0,0,32'h0,         1,1,2,0));
        tbl.push_back(v(0,1,0,0,32'h0,         1,1,1,0));
        tbl.push_back(v(0,0,0,0,32'h0,         1,0,0,0));
        tbl.push_back(v(1,0,0,0,32'h2000_0000, 1,0,0,0));
        tbl.push_back(v(1,0,0,1,32'h2000_0004, 1,1,1,0));
        tbl.push_back(v(1,0,0,0,32'h2000_0008, 0,1,2,1));
        tbl.push_back(v(1,1,0,0,32'h2000_0008, 0,1,2,1));
        tbl.push_back(v(1,1,0,0,32'h2000_0008, 0,1,1,1));
        tbl.push_back(v(1,0,0,0,32'h2000_0008, 1,0,0,0));
        tbl.push_back(v(0,1,0,0,32'h0,         1,1,1,0));
        tbl.push_back(v(0,0,0,0,32'h0,         1,0,0,0));

        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_ready", 64'(fetch_entry_ready_o), 64'd1);
        chk("rst_valid", 64'(fetch_entry_valid_o), 64'd0);
        chk("rst_usage", 64'(usage_o), 64'd0);
        chk("rst_exblk", 64'(ex_block_o), 64'd0);
        chk_entry("rst_entry", fetch_entry_o, '0);
        rst_ni = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            chk($sformatf("vec%0d_ready", i), 64'(fetch_entry_ready_o), 64'(tbl[i].e_rdy));
            chk($sformatf("vec%0d_valid", i), 64'(fetch_entry_valid_o), 64'(tbl[i].e_vld));
            chk($sformatf("vec%0d_usage", i), 64'(usage_o), 64'(tbl[i].e_use));
            chk($sformatf("vec%0d_exblk", i), 64'(ex_block_o), 64'(tbl[i].e_blk));
            if (i == 1) chk("vec1_addr", 64'(fetch_entry_o.address), 64'h8000_0000);
            step(tbl[i].vin, tbl[i].rdy, tbl[i].fl, mk(tbl[i].addr, tbl[i].exv));
        end

        // Simultaneous push and pop at a steady occupancy of two.
        step(1'b1, 1'b0, 1'b0, mk(32'h3000_0000, 1'b0));
        step(1'b1, 1'b0, 1'b0, mk(32'h3000_0004, 1'b0));
        for (int i = 0; i < 10; i++) begin
            chk("pp_usage", 64'(usage_o), 64'd2);
            step(1'b1, 1'b1, 1'b0, mk(32'h3000_0008 + 32'(i) * 4, 1'b0));
        end
        chk("pp_head", 64'(fetch_entry_o.address), 64'h3000_0028);
        idle(1);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, mk(32'h0, 1'b0));

        // Flush with three queued, concurrent with a push and a pop.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, mk(32'h4000_0000 + 32'(i) * 4, 1'b0));
        step(1'b1, 1'b1, 1'b1, mk(32'h4bad_0000, 1'b0));
        chk("fl_usage", 64'(usage_o), 64'd0);
        chk("fl_valid", 64'(fetch_entry_valid_o), 64'd0);
        chk("fl_ready", 64'(fetch_entry_ready_o), 64'd1);
        chk("fl_exblk", 64'(ex_block_o), 64'd0);
        idle(3);

        // Flush while holding on an exception entry.
        step(1'b1, 1'b0, 1'b0, mk(32'h5000_0000, 1'b1));
        chk("flex_blk", 64'(ex_block_o), 64'd1);
        step(1'b0, 1'b0, 1'b1, mk(32'h0, 1'b0));
        chk("flex_unblk", 64'(ex_block_o), 64'd0);
        chk("flex_ready", 64'(fetch_entry_ready_o), 64'd1);

        // Asynchronous reset with three entries queued.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, mk(32'h6000_0000 + 32'(i) * 4, 1'b0));
        fetch_entry_valid_i = 1'b0;
        #3;
        rst_ni = 1'b0;
        #1;
        chk("arst_ready", 64'(fetch_entry_ready_o), 64'd1);
        chk("arst_valid", 64'(fetch_entry_valid_o), 64'd0);
        chk("arst_usage", 64'(usage_o), 64'd0);
        chk("arst_exblk", 64'(ex_block_o), 64'd0);
        chk_entry("arst_entry", fetch_entry_o, '0);
        mq.delete();
        mhold = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, mk(32'h0, 1'b0));

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 19) == 0),
                 mk($urandom, 1'($urandom_range(0, 7) == 0)));
        end
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, mk(32'h0, 1'b0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
